// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the byte-wide memory path:
//               access size encoding, address-region map, adapter state
//               encoding and small decode helpers used by mem_word_adapter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size as presented on the request port.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  // 2 MiB regions, compared against addr[31:21].
  localparam logic [10:0] REGION_SRAM = 11'h000;
  localparam logic [10:0] REGION_SD   = 11'h001;

  // Adapter sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // True when the access must be rejected without touching memory:
  // illegal size, misalignment, or an address outside the mapped regions.
  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [10:0] region,
                                        input logic [1:0]  low);
    logic unmapped;
    logic misaligned;
    unmapped = (region != REGION_SRAM) && (region != REGION_SD);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = low[0];
      SZ_WORD: misaligned = (low != 2'b00);
      default: misaligned = 1'b1;
    endcase
    return unmapped || misaligned;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_extend
// Description : Combinational zero/sign extension of an assembled
//               little-endian load value according to access size.
// Ports       : size      - access size (byte/half/word)
//               is_signed - sign-extend instead of zero-extend
//               data      - assembled load bytes, LSB-aligned
//               result    - extended 32-bit load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extend
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        is_signed,
  input  logic [31:0] data,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    case (size)
      SZ_BYTE: result = {{24{is_signed & data[7]}}, data[7:0]};
      SZ_HALF: result = {{16{is_signed & data[15]}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_word_adapter.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_adapter
// Description : Converts one aligned byte/half/word load-store request into
//               1, 2 or 4 little-endian byte transactions on the byte-wide
//               memory controller, then returns a single-cycle response.
// Ports       : clk, reset_n (async, active-low)
//               req_*  - valid/ready request port from the load/store unit
//               resp_* - one-cycle response pulse (no backpressure)
//               mem_*  - strobe/ready handshake to the memory controller
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_adapter
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_in_data,
  input  logic [7:0]  mem_out_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic        mem_ready
);

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [7:0]  r_mem_in_data;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  size_e       r_size;
  logic        r_write;
  logic        r_signed;
  logic        r_error;

  logic        w_accept;
  logic        w_req_err;
  logic        w_last_byte;
  logic [1:0]  w_idx_next;
  logic [31:0] w_ext;

  assign req_ready   = (r_state == S_IDLE) && mem_ready;
  assign w_accept    = req_valid && req_ready;
  assign w_req_err   = access_error(req_size, req_addr[31:21], req_addr[1:0]);
  assign w_last_byte = (r_idx == r_last);
  assign w_idx_next  = r_idx + 2'd1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_req_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      // mem_ready high here guarantees the controller samples the next strobe,
      // so the following byte can be issued without an idle cycle.
      S_WAIT:  if (mem_ready) w_next = w_last_byte ? S_RESP : S_ISSUE;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, byte sequencing and load assembly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base        <= 32'd0;
      r_wdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_mem_addr    <= 32'd0;
      r_mem_in_data <= 8'd0;
      r_idx         <= 2'd0;
      r_last        <= 2'd0;
      r_size        <= SZ_BYTE;
      r_write       <= 1'b0;
      r_signed      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= 32'd0;
            r_idx    <= 2'd0;
            r_last   <= last_index(req_size);
            r_size   <= size_e'(req_size);
            r_write  <= req_write;
            r_signed <= req_signed;
            r_error  <= w_req_err;
            // Rejected requests leave the memory-side outputs untouched.
            if (!w_req_err) begin
              r_mem_addr    <= req_addr;
              r_mem_in_data <= req_wdata[7:0];
            end
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            if (!r_write) r_rdata[{r_idx, 3'b000} +: 8] <= mem_out_data;
            if (!w_last_byte) begin
              r_idx         <= w_idx_next;
              r_mem_addr    <= r_base + 32'(w_idx_next);
              r_mem_in_data <= r_wdata[{w_idx_next, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

  mem_load_extend u_extend (
    .size      (r_size),
    .is_signed (r_signed),
    .data      (r_rdata),
    .result    (w_ext)
  );

  // Outputs decoded from the state register
  always_comb begin
    mem_read   = (r_state == S_ISSUE) && !r_write;
    mem_write  = (r_state == S_ISSUE) &&  r_write;
    resp_valid = (r_state == S_RESP);
    resp_error = (r_state == S_RESP) && r_error;
    resp_rdata = 32'd0;
    if ((r_state == S_RESP) && !r_write && !r_error) resp_rdata = w_ext;
  end

  assign mem_addr    = r_mem_addr;
  assign mem_in_data = r_mem_in_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_word_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_word_adapter
// Description : Self-checking bench for mem_word_adapter. A behavioural
//               byte-memory controller (SRAM and slow SD region) sits on the
//               memory side; expected responses, latencies and byte strobes
//               come from a reference memory and arithmetic access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_word_adapter;

  localparam int SRAM_LAT = 1;    // cycles mem_ready stays low per SRAM byte
  localparam int SD_LAT   = 20;   // cycles mem_ready stays low per SD byte

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [7:0]  mem_in_data;
  logic [7:0]  mem_out_data;
  logic        mem_write;
  logic        mem_read;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_word_adapter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_addr     (mem_addr),
    .mem_in_data  (mem_in_data),
    .mem_out_data (mem_out_data),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_ready    (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory arrays cover the low 1 KiB of SRAM and of SD.
  function automatic int ridx(input logic [31:0] a);
    return int'({a[21], a[9:0]});
  endfunction

  logic [7:0] ctl_mem [0:2047];
  logic [7:0] ref_mem [0:2047];

  // ---------------- behavioural byte-memory controller ----------------
  int busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 0;
      mem_ready <= 1'b1;
    end else if (mem_read || mem_write) begin
      busy      <= (mem_addr[31:21] == 11'h001) ? SD_LAT : SRAM_LAT;
      mem_ready <= 1'b0;
      if (mem_write) ctl_mem[ridx(mem_addr)] <= mem_in_data;
      else           mem_out_data <= ctl_mem[ridx(mem_addr)];
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy      <= 0;
      mem_ready <= 1'b1;
    end
  end

  // ---------------- strobe monitor ----------------
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [7:0]  d;
  } strobe_t;
  strobe_t slog[$];

  always @(negedge clk) begin
    if (reset_n && (mem_read || mem_write)) begin
      check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      check("strobe_while_busy", 32'(mem_ready), 32'd1);
      slog.push_back('{w: mem_write, a: mem_addr, d: mem_in_data});
    end
  end

  // ---------------- one transaction against the reference model ----------------
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    int          n;
    int          exp_lat;
    int          lat;
    int          cyc;
    logic        err;
    logic [31:0] exp_rd;
    int          nchk;

    err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
          (sz == 2'd2 && a % 4 != 0) || (a >= 32'h0040_0000);
    n   = err ? 0 : (1 << sz);
    exp_lat = err ? 1 :
              n * (((a >= 32'h0020_0000) ? SD_LAT : SRAM_LAT) + 2) + 1;
    exp_rd = 32'd0;
    if (!err && !w) begin
      for (int i = 0; i < n; i++)
        exp_rd = exp_rd + (32'(ref_mem[ridx(a + 32'(i))]) << (8 * i));
      if (sg && n < 4 && exp_rd >= (32'd1 << (8 * n - 1)))
        exp_rd = exp_rd - (32'd1 << (8 * n));
    end
    if (!err && w)
      for (int i = 0; i < n; i++) ref_mem[ridx(a + 32'(i))] = wd[8*i +: 8];

    slog.delete();
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    cyc = 0;
    while (!req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request bus so an adapter that fails to latch is exposed.
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_error"}, 32'(resp_error), 32'(err));
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    @(negedge clk);
    check({tag, "_pulse_one_cycle"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_after_resp"}, 32'(req_ready), 32'd1);

    check({tag, "_n_strobes"}, 32'(slog.size()), 32'(n));
    nchk = (slog.size() < n) ? slog.size() : n;
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s_strobe%0d_addr", tag, i), slog[i].a, a + 32'(i));
      check($sformatf("%s_strobe%0d_kind", tag, i), 32'(slog[i].w), 32'(w));
      if (w) check($sformatf("%s_strobe%0d_data", tag, i), 32'(slog[i].d), 32'(wd[8*i +: 8]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_read"},    32'(mem_read), 32'd0);
    check({tag, "_mem_write"},   32'(mem_write), 32'd0);
    check({tag, "_mem_addr"},    mem_addr, 32'd0);
    check({tag, "_mem_in_data"}, 32'(mem_in_data), 32'd0);
    check({tag, "_resp_valid"},  32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"},  resp_rdata, 32'd0);
    check({tag, "_resp_error"},  32'(resp_error), 32'd0);
    check({tag, "_req_ready"},   32'(req_ready), 32'(mem_ready));
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    for (int i = 0; i < 2048; i++) begin
      ctl_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_req_ready_high", 32'(req_ready), 32'd1);
    reset_n = 1'b1;

    // Word store / load round trip
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, "st_word");
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, "ld_word");

    // Byte 0x80 signed and unsigned
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_0080, "st_byte");
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0005, 32'h0, "ld_sbyte");
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0005, 32'h0, "ld_ubyte");

    // Halfword 0x8001 signed and unsigned
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_0010, 32'h0000_8001, "st_half");
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0, "ld_shalf");
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0, "ld_uhalf");

    // Rejected accesses
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0, "err_half_mis");
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'h1234_5678, "err_word_mis");
    do_req(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, "err_size3");
    do_req(1'b0, 2'd2, 1'b0, 32'h0040_0000, 32'h0, "err_unmapped");

    // SD word load with distinct bytes to expose ordering
    for (int i = 0; i < 4; i++) begin
      ctl_mem[ridx(32'h0020_0010 + 32'(i))] = 8'hD4 - 8'(i * 'h11);
      ref_mem[ridx(32'h0020_0010 + 32'(i))] = 8'hD4 - 8'(i * 'h11);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h0020_0010, 32'h0, "sd_word");
    check("sd_word_value_direct", resp_rdata, 32'h0);

    // Reset during the second byte of a word load
    slog.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_0100; req_wdata = 32'h0;
    cyc = 0;
    while (!req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_second_strobe", 32'(mem_read), 32'd1);
    check("rst_second_addr", mem_addr, 32'h0000_0101);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rst_no_resp", 32'(seen), 32'd0);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'h0, "post_rst_byte");

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      a = 32'h0000_0000;
      else if (r < 85) a = 32'h0020_0000;
      else if (r < 93) a = 32'h0040_0000;
      else             a = 32'h8000_0000;
      a  = a + 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 99) < 8) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0)
        a = a - (a % (32'd1 << sz));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
